clk_div_multi: RTL and testbench



---
 rtl/clk_div_multi.sv | 100 ++++++++++
 tb/tb_clk_div_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers sharing one
// input clock. Each channel produces a 50 % square enable-clock (Clkout) and
// a one-cycle Tick per period. New divisors wait in a shadow register while
// a channel is running and are only applied at a period boundary, so a
// channel never glitches and its counter never runs past its terminal count.

module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 39_999_999
) (
    input  logic              Clkin,
    input  logic              Rstn,
    input  logic [NUM_CH-1:0] En,
    input  logic              Sync,
    input  logic              Wr_en,
    input  logic [CH_W-1:0]   Wr_ch,
    input  logic [CNT_W-1:0]  Wr_div,
    output logic [NUM_CH-1:0] Clkout,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Pending
);

    // Reset terminal count, truncated to the counter width.
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    // Per-channel state.
    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [CNT_W-1:0]  r_active [NUM_CH];
    logic [CNT_W-1:0]  r_shadow [NUM_CH];
    logic [NUM_CH-1:0] r_clkout;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_pending;

    // All outputs come straight from registers; nothing combinational
    // reaches the pins.
    assign Clkout  = r_clkout;
    assign Tick    = r_tick;
    assign Pending = r_pending;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gCh

        // Decoded per-channel controls. Write addresses at or beyond NUM_CH
        // never match any channel and are therefore ignored.
        logic             w_wr;
        logic             w_wrap;
        logic             w_sync;
        logic [CNT_W-1:0] w_boundaryDiv;

        assign w_wr   = Wr_en && (Wr_ch == CH_W'(gi));
        assign w_sync = Sync && En[gi];
        assign w_wrap = En[gi] && (r_cnt[gi] == r_active[gi]);

        // Divisor to adopt at any period boundary (wrap, sync, stop): a
        // same-cycle write wins, otherwise a waiting shadow, otherwise keep.
        always_comb begin
            w_boundaryDiv = r_active[gi];
            if (w_wr) begin
                w_boundaryDiv = Wr_div;
            end else if (r_pending[gi]) begin
                w_boundaryDiv = r_shadow[gi];
            end
        end

        // Channel sequencer: Sync beats a stopped channel, which beats the
        // normal wrap/count behaviour. Stopping is treated as a period
        // boundary too, so a waiting divisor is applied rather than lost.
        always_ff @(posedge Clkin or negedge Rstn) begin
            if (!Rstn) begin
                r_cnt[gi]     <= '0;
                r_active[gi]  <= DEF_DIV;
                r_shadow[gi]  <= DEF_DIV;
                r_clkout[gi]  <= 1'b0;
                r_tick[gi]    <= 1'b0;
                r_pending[gi] <= 1'b0;
            end else if (w_sync || !En[gi]) begin
                r_cnt[gi]     <= '0;
                r_clkout[gi]  <= 1'b0;
                r_tick[gi]    <= 1'b0;
                r_active[gi]  <= w_boundaryDiv;
                r_pending[gi] <= 1'b0;
            end else if (w_wrap) begin
                r_cnt[gi]     <= '0;
                r_clkout[gi]  <= ~r_clkout[gi];
                r_tick[gi]    <= 1'b1;
                r_active[gi]  <= w_boundaryDiv;
                r_pending[gi] <= 1'b0;
            end else begin
                r_cnt[gi]  <= r_cnt[gi] + 1'b1;
                r_tick[gi] <= 1'b0;
                if (w_wr) begin
                    r_shadow[gi]  <= Wr_div;
                    r_pending[gi] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed scenarios followed by a random phase, all
// compared every cycle against a period-level reference model of the
// divider channels.

module tb_clk_div_multi;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 8;
    localparam int DEF    = 3;

    logic              Clkin = 1'b0;
    logic              Rstn;
    logic [NUM_CH-1:0] En;
    logic              Sync;
    logic              Wr_en;
    logic [CH_W-1:0]   Wr_ch;
    logic [CNT_W-1:0]  Wr_div;
    logic [NUM_CH-1:0] Clkout;
    logic [NUM_CH-1:0] Tick;
    logic [NUM_CH-1:0] Pending;

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model: each channel is described by where it is inside the
    // current period, how many periods it has completed since phase 0, its
    // divisor and an optional waiting divisor.
    int mPos     [NUM_CH];
    int mPeriods [NUM_CH];
    int mDiv     [NUM_CH];
    int mNextDiv [NUM_CH];
    bit mHasNext [NUM_CH];
    bit mTickNow [NUM_CH];

    clk_div_multi #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)
    ) dut (
        .Clkin(Clkin), .Rstn(Rstn), .En(En), .Sync(Sync),
        .Wr_en(Wr_en), .Wr_ch(Wr_ch), .Wr_div(Wr_div),
        .Clkout(Clkout), .Tick(Tick), .Pending(Pending)
    );

    always #5 Clkin = ~Clkin;

    function automatic void modelReset();
        for (int i = 0; i < NUM_CH; i++) begin
            mPos[i] = 0; mPeriods[i] = 0; mDiv[i] = DEF;
            mNextDiv[i] = DEF; mHasNext[i] = 0; mTickNow[i] = 0;
        end
    endfunction

    // Advance the model by one Clkin edge using the inputs presented to it.
    function automatic void modelEdge();
        for (int i = 0; i < NUM_CH; i++) begin
            bit writeHere = Wr_en && (int'(Wr_ch) == i);
            int boundaryDiv = writeHere ? int'(Wr_div) : (mHasNext[i] ? mNextDiv[i] : mDiv[i]);
            if (!En[i] || Sync) begin
                mPos[i] = 0; mPeriods[i] = 0; mTickNow[i] = 0;
                mDiv[i] = boundaryDiv; mHasNext[i] = 0;
            end else if (mPos[i] == mDiv[i]) begin
                mPos[i] = 0; mPeriods[i]++; mTickNow[i] = 1;
                mDiv[i] = boundaryDiv; mHasNext[i] = 0;
            end else begin
                mPos[i]++; mTickNow[i] = 0;
                if (writeHere) begin
                    mNextDiv[i] = int'(Wr_div); mHasNext[i] = 1;
                end
            end
        end
    endfunction

    function automatic logic [NUM_CH-1:0] expClkout();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = mPeriods[i][0];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] expTick();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = mTickNow[i];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] expPending();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = mHasNext[i];
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [NUM_CH-1:0] observed,
                               input logic [NUM_CH-1:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAgainstModel();
        checkOutput("Clkout", Clkout, expClkout());
        checkOutput("Tick", Tick, expTick());
        checkOutput("Pending", Pending, expPending());
    endtask

    // One Clkin edge: the model consumes the same inputs the DUT sampled,
    // then outputs are compared 1 time unit later.
    task automatic applyStimulus();
        @(posedge Clkin);
        modelEdge();
        #1;
        checkAgainstModel();
    endtask

    task automatic writeDiv(input int ch, input int div);
        Wr_en = 1'b1; Wr_ch = CH_W'(ch); Wr_div = CNT_W'(div);
        applyStimulus();
        Wr_en = 1'b0;
    endtask

    initial begin
        Rstn = 1'b0; En = '0; Sync = 1'b0; Wr_en = 1'b0; Wr_ch = '0; Wr_div = '0;
        modelReset();
        #12;
        checkOutput("resetClkout", Clkout, 3'b000);
        checkOutput("resetTick", Tick, 3'b000);
        checkOutput("resetPending", Pending, 3'b000);
        @(negedge Clkin);
        Rstn = 1'b1;
        @(posedge Clkin);
        #1;

        // Default divisor 3 on channel 0: Tick every 4 edges, Clkout period 8.
        En = 3'b001;
        for (int e = 1; e <= 12; e++) begin
            applyStimulus();
            if (e == 4) begin
                checkOutput("t1Tick4", Tick, 3'b001);
                checkOutput("t1Clk4", Clkout, 3'b001);
            end
            if (e == 8) begin
                checkOutput("t1Tick8", Tick, 3'b001);
                checkOutput("t1Clk8", Clkout, 3'b000);
            end
        end

        // Channel 1: write D=1 at cnt=1, held in the shadow until the wrap.
        En = 3'b011;
        applyStimulus();
        writeDiv(1, 1);
        checkOutput("t2Pend", {2'b00, Pending[1]}, 3'b001);
        for (int e = 0; e < 8; e++) applyStimulus();

        // D=0 written to the stopped channel 2 applies at once.
        writeDiv(2, 0);
        checkOutput("t3PendIdle", {2'b00, Pending[2]}, 3'b000);
        En = 3'b111;
        applyStimulus();
        checkOutput("t3Tick1", {2'b00, Tick[2]}, 3'b001);
        checkOutput("t3Clk1", {2'b00, Clkout[2]}, 3'b001);
        applyStimulus();
        checkOutput("t3Clk2", {2'b00, Clkout[2]}, 3'b000);
        for (int e = 0; e < 4; e++) applyStimulus();

        // All channels D=5, staggered start, then Sync realigns them.
        En = 3'b000;
        applyStimulus();
        for (int c = 0; c < NUM_CH; c++) writeDiv(c, 5);
        En = 3'b001; applyStimulus(); applyStimulus();
        En = 3'b011; applyStimulus(); applyStimulus();
        En = 3'b111; applyStimulus(); applyStimulus();
        Sync = 1'b1;
        applyStimulus();
        Sync = 1'b0;
        checkOutput("t4SyncClk", Clkout, 3'b000);
        checkOutput("t4SyncTick", Tick, 3'b000);
        for (int e = 1; e <= 6; e++) begin
            applyStimulus();
            if (e == 6) checkOutput("t4Aligned", Tick, 3'b111);
            if (e == 5) checkOutput("t4NotYet", Tick, 3'b000);
        end

        // Out-of-range channel write is ignored; then stop channel 0 mid-period.
        applyStimulus();
        writeDiv(3, 2);
        checkOutput("t5Ignored", Pending, 3'b000);
        En = 3'b110;
        applyStimulus();
        checkOutput("t5StopClk", {2'b00, Clkout[0]}, 3'b000);
        checkOutput("t5StopTick", {2'b00, Tick[0]}, 3'b000);

        // Async reset with a pending shadow, away from any clock edge.
        En = 3'b000; applyStimulus();
        En = 3'b111; applyStimulus();
        writeDiv(1, 2);
        checkOutput("t6Pend", {2'b00, Pending[1]}, 3'b001);
        #2;
        Rstn = 1'b0;
        #1;
        modelReset();
        checkOutput("t6RstClk", Clkout, 3'b000);
        checkOutput("t6RstTick", Tick, 3'b000);
        checkOutput("t6RstPend", Pending, 3'b000);
        En = 3'b001;
        #2;
        Rstn = 1'b1;
        for (int e = 1; e <= 4; e++) applyStimulus();
        checkOutput("t6DefDiv", Tick, 3'b001);

        // Random phase: sporadic enables, syncs and writes (some out of range).
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) En = NUM_CH'($urandom_range(0, 7));
            Sync   = ($urandom_range(0, 40) == 0);
            Wr_en  = ($urandom_range(0, 5) == 0);
            Wr_ch  = CH_W'($urandom_range(0, 3));
            Wr_div = CNT_W'($urandom_range(0, 7));
            applyStimulus();
        end
        Wr_en = 1'b0; Sync = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
